// File: rtl/lsu_io_pkg.sv
// Shared definitions for the load-store unit: address map, access sizes and
// byte-lane helpers used by the RAM and the memory-mapped registers.
package lsu_pkg;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] LEDR_ADDR    = 32'h1000_0000;
  localparam logic [31:0] LEDG_ADDR    = 32'h1000_1000;
  localparam logic [31:0] HEX_ADDR     = 32'h1000_2000;
  localparam logic [31:0] LCD_ADDR     = 32'h1000_3000;
  localparam logic [31:0] SW_ADDR      = 32'h1001_0000;
  localparam logic [31:0] IO_WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_funct3_e;

  // Lanes touched by a store; invalid encodings enable nothing.
  function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                             input logic [1:0] offs);
    case (funct3)
      LSU_B, LSU_BU: byte_enable = 4'b0001 << offs;
      LSU_H, LSU_HU: byte_enable = offs[1] ? 4'b1100 : 4'b0011;
      LSU_W:         byte_enable = 4'b1111;
      default:       byte_enable = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    merge_lanes = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merge_lanes[8*i +: 8] = new_word[8*i +: 8];
    end
  endfunction

endpackage

// File: rtl/lsu_io_sw_debounce.sv
// Two-flop synchroniser followed by a whole-vector debouncer for the slide
// switches; a new value is accepted only after it has differed long enough.
module sw_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_raw,
  output logic [31:0] o_stable
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYC - 1);

  logic [31:0]   sync1;
  logic [31:0]   sync2;
  logic [31:0]   stable;
  logic [CW-1:0] cnt;

  // Only a return to the accepted value restarts the count, so a bouncing
  // vector that never settles back is still accepted once the limit is hit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      sync1 <= i_raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LIMIT) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_stable = stable;

endmodule

// File: rtl/lsu_io.sv
// Load-store unit: data RAM plus memory-mapped LED/HEX/LCD registers and the
// debounced switch input, with RV32I sizing and sign/zero extension.
module lsu_io
  import lsu_pkg::*;
#(
  parameter int DMEM_AW      = 13,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_wren,
  input  logic        i_rden,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [6:0]  o_io_hex07,
  output logic [31:0] o_io_lcd,
  input  logic [31:0] i_io_sw
);

  localparam int WORDS = 2 ** (DMEM_AW - 2);

  logic [31:0]         mem [WORDS];
  logic [31:0]         ledr, ledg, lcd, sw_stable;
  logic [6:0]          hex;
  logic [DMEM_AW-3:0]  ram_idx;
  logic [31:0]         io_word;
  logic                is_ram, hit_ledr, hit_ledg, hit_hex, hit_lcd, hit_sw;
  logic                mis_raw, do_store;
  logic [3:0]          be;
  logic [31:0]         wrep, sel_word, shifted;
  logic [7:0]          byte_v;
  logic [15:0]         half_v;

  sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sw_debounce (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_raw    (i_io_sw),
    .o_stable (sw_stable)
  );

  assign ram_idx  = i_addr[DMEM_AW-1:2];
  assign io_word  = i_addr & IO_WORD_MASK;
  assign is_ram   = (i_addr >> DMEM_AW) == RAM_BASE;
  assign hit_ledr = io_word == LEDR_ADDR;
  assign hit_ledg = io_word == LEDG_ADDR;
  assign hit_hex  = io_word == HEX_ADDR;
  assign hit_lcd  = io_word == LCD_ADDR;
  assign hit_sw   = io_word == SW_ADDR;

  // Invalid encodings follow the word alignment rule since loads treat them as W.
  always_comb begin
    mis_raw = 1'b0;
    wrep    = i_wdata;
    case (i_funct3)
      LSU_B, LSU_BU: wrep = {4{i_wdata[7:0]}};
      LSU_H, LSU_HU: begin
        mis_raw = i_addr[0];
        wrep    = {2{i_wdata[15:0]}};
      end
      default:       mis_raw = |i_addr[1:0];
    endcase
  end

  assign be           = byte_enable(i_funct3, i_addr[1:0]);
  assign do_store     = i_wren & ~mis_raw & ~i_reset;
  assign o_misaligned = (i_rden | i_wren) & mis_raw;

  always_ff @(posedge i_clk) begin
    if (do_store && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[ram_idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  // The switch slot is read-only and HEX keeps only the low seven bits of lane 0.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      hex  <= 7'h00;
    end else if (do_store) begin
      if (hit_ledr) ledr <= merge_lanes(ledr, wrep, be);
      if (hit_ledg) ledg <= merge_lanes(ledg, wrep, be);
      if (hit_lcd)  lcd  <= merge_lanes(lcd, wrep, be);
      if (hit_hex && be[0]) hex <= wrep[6:0];
    end
  end

  always_comb begin
    sel_word = '0;
    if (is_ram)        sel_word = mem[ram_idx];
    else if (hit_ledr) sel_word = ledr;
    else if (hit_ledg) sel_word = ledg;
    else if (hit_hex)  sel_word = {25'b0, hex};
    else if (hit_lcd)  sel_word = lcd;
    else if (hit_sw)   sel_word = sw_stable;
  end

  assign shifted = sel_word >> {i_addr[1:0], 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = i_addr[1] ? sel_word[31:16] : sel_word[15:0];

  always_comb begin
    o_rdata = '0;
    if (i_rden && !mis_raw) begin
      case (i_funct3)
        LSU_B:   o_rdata = {{24{byte_v[7]}}, byte_v};
        LSU_BU:  o_rdata = {24'b0, byte_v};
        LSU_H:   o_rdata = {{16{half_v[15]}}, half_v};
        LSU_HU:  o_rdata = {16'b0, half_v};
        default: o_rdata = sel_word;
      endcase
    end
  end

  assign o_io_ledr  = ledr;
  assign o_io_ledg  = ledg;
  assign o_io_lcd   = lcd;
  assign o_io_hex07 = hex;

endmodule

// File: doc/lsu_io.md
Name: lsu_io

Overview:
- Load-store unit directly downstream of the single-cycle core's ALU address output; replaces the bare data memory.
- Decodes the effective address into on-chip data RAM or memory-mapped I/O.
- Applies RV32I byte/half/word sizing with sign or zero extension.
- Owns the registered LED/HEX/LCD output ports and a synchronised, debounced switch input.

Parameters:
- DMEM_AW, 13, byte-address width of data RAM (2^13 = 8 KiB, 2048 words)
- DEBOUNCE_CYC, 16, consecutive stable cycles required before a switch change is accepted (>= 2)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_addr  in  32  effective byte address from ALU
- i_wdata  in  32  store data (rs2), right-aligned
- i_wren  in  1  store enable for this cycle
- i_rden  in  1  load enable for this cycle
- i_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- o_rdata  out  32  load result, extended, combinational same cycle
- o_misaligned  out  1  current access misaligned (combinational)
- o_io_ledr  out  32  red LED register
- o_io_ledg  out  32  green LED register
- o_io_hex07  out  7  seven-segment register
- o_io_lcd  out  32  LCD register
- i_io_sw  in  32  raw asynchronous switches

Behaviour:
- Clock and reset: one clock, i_clk; reset is synchronous and active-high on i_reset.
- Address map (a[31:0]):
  - 0x0000_0000..0x0000_1FFF: RAM
  - 0x1000_0000: LEDR
  - 0x1000_1000: LEDG
  - 0x1000_2000: HEX (bits 6:0)
  - 0x1000_3000: LCD
  - 0x1001_0000: SW (read-only)
  - Each I/O slot decodes a single word (a[1:0] selects byte lanes).
  - Any other address is unmapped: loads return 0, stores are ignored, no error flag.
- Alignment:
  - H requires a[0]=0; W requires a[1:0]=00; B is always aligned.
  - Misaligned: o_misaligned=1, store suppressed, o_rdata=0.
- Store timing: the write commits on the rising i_clk edge in the cycle i_wren=1. Byte-enable lanes:
  - SB: lane a[1:0]
  - SH: lanes {a[1],0} and {a[1],1}
  - SW: all four lanes
  - Store data is replicated: byte to all lanes, half to both halves.
- HEX register: only lane 0 bits 6:0 are written; bit 7 is dropped.
- SW region: stores are ignored.
- Load timing: asynchronous read, same cycle.
  - Selected word → lane extract → sign extend (B, H) or zero extend (BU, HU).
  - When i_rden=0, o_rdata=0.
  - I/O register reads return the current register value (HEX zero-extended to 32 bits).
- Read-after-write: a load in the cycle after a store sees the new data. A load in the same cycle as a store (never issued by the core) returns the old data.
- Invalid funct3 (011, 110, 111): treated as W for loads; store suppressed.
- Reset:
  - o_io_ledr = o_io_ledg = o_io_lcd = 0; o_io_hex07 = 7'h00.
  - Synchroniser flops, debounce counter and stable switch value all 0.
  - RAM contents are not cleared.
  - Reset has priority over a coincident store.
- Switch path: 2-flop synchroniser, then a debouncer operating on the whole 32-bit vector.
  - If sync == stable: counter resets to 0.
  - Otherwise the counter increments; when the counter reaches DEBOUNCE_CYC-1 and sync still != stable, stable <= sync and the counter resets.
  - Any change of sync during counting does not reset the counter; only equality with stable does.
  - Latency from an i_io_sw edge to the readable value: 2 + DEBOUNCE_CYC cycles.
  - Counter width is $clog2(DEBOUNCE_CYC); it saturates, never wraps.
- Invariant: i_wren and i_rden are never asserted together by the controller. If they are, the store and load both proceed as specified above.

Decomposition:
- Package lsu_pkg holds:
  - address base/mask localparams for each region
  - funct3 encodings as an enum (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - a function for byte-enable generation
- Sub-module sw_debounce contains the synchroniser plus the debounce counter (ports i_clk, i_reset, i_raw[31:0], o_stable[31:0]).
- The RAM array and I/O registers live in lsu_io.

Test Plan:
- Reset, then hold i_reset 1 while SW 0x1000_0000 ← 0xFFFF_FFFF → o_io_ledr stays 0; after release, the same store → o_io_ledr=0xFFFF_FFFF next cycle.
- SW 0x100 ← 0x8081_7F80; LB 0x100 → 0xFFFF_FF80; LBU 0x101 → 0x0000_007F; LH 0x102 → 0xFFFF_8081; LHU 0x102 → 0x0000_8081; LW → 0x8081_7F80.
- SB 0x203 ← 0x0000_00AB over word 0x1122_3344 → LW 0x200 = 0xAB22_3344; SH 0x1000_1002 ← 0xBEEF → o_io_ledg=0xBEEF_0000.
- LH 0x101 and SW 0x102 ← 0x1234_5678 → o_misaligned=1, o_rdata=0, RAM and registers unchanged. Store to 0x2000_0000 → no effect; load from it → 0.
- i_io_sw 0→0x0000_00A5 → LW 0x1001_0000 returns 0 at cycle 2+DEBOUNCE_CYC-1 and 0xA5 at 2+DEBOUNCE_CYC. A 5-cycle glitch to 0x1 → never visible.
- SW 0x1000_2000 ← 0xFFFF_FFFF → o_io_hex07=7'h7F; LW 0x1000_2000 → 0x0000_007F.
